seeg_axil_regs: RTL and testbench

SEEG_AXIL_REGS -- requirements
Module: seeg_axil_regs

---
 rtl/seeg_regs_pkg.sv | 48 ++++
 rtl/seeg_cmd_pulse.sv | 35 +++
 rtl/seeg_axil_regs.sv | 210 +++++++++++++++++++++
 tb/tb_seeg_axil_regs.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seeg_regs_pkg.sv
// Shared definitions for the SEEG AXI4-Lite register block.
// Holds the word-index map, the CMD bit positions, the command-bit struct
// and a helper that extracts the command bits from a raw CMD word.
package seeg_regs_pkg;

    localparam int unsigned NUM_WORDS = 32;

    // Word indices (byte address bits [6:2]).
    localparam logic [4:0] IDX_CMD      = 5'd0;
    localparam logic [4:0] IDX_STATUS   = 5'd1;
    localparam logic [4:0] IDX_STIM0    = 5'd3;
    localparam logic [4:0] IDX_STIM1    = 5'd4;
    localparam logic [4:0] IDX_STIM2    = 5'd5;
    localparam logic [4:0] IDX_STIM3    = 5'd6;
    localparam logic [4:0] IDX_BATCH    = 5'd19;
    localparam logic [4:0] IDX_LOOPBACK = 5'd20;

    // Bit positions inside the CMD word.
    localparam int unsigned CMD_START_RECORD   = 0;
    localparam int unsigned CMD_STOP_RECORD    = 1;
    localparam int unsigned CMD_START_ZCHECK   = 2;
    localparam int unsigned CMD_START_STIM_FIN = 6;
    localparam int unsigned CMD_START_STIM_INF = 7;
    localparam int unsigned CMD_STOP_STIM_INF  = 8;

    // The defined command bits, gathered into one vector.
    typedef struct packed {
        logic stop_stim_inf;
        logic start_stim_inf;
        logic start_stim_fin;
        logic start_zcheck;
        logic stop_record;
        logic start_record;
    } cmd_bits_t;

    // Pick the defined command bits out of a CMD word; undefined bits are dropped.
    function automatic cmd_bits_t cmd_bits_from_word(input logic [31:0] word);
        cmd_bits_t c;
        c.start_record   = word[CMD_START_RECORD];
        c.stop_record    = word[CMD_STOP_RECORD];
        c.start_zcheck   = word[CMD_START_ZCHECK];
        c.start_stim_fin = word[CMD_START_STIM_FIN];
        c.start_stim_inf = word[CMD_START_STIM_INF];
        c.stop_stim_inf  = word[CMD_STOP_STIM_INF];
        return c;
    endfunction

endpackage

// File: rtl/seeg_cmd_pulse.sv
// Registered 0->1 edge detector over the command bits.
// Ports: clk, rst_n (async active-low), cmd_i (current CMD bits),
//        pulse_o (one-cycle pulse per bit that rose, registered).
module seeg_cmd_pulse
    import seeg_regs_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  cmd_bits_t cmd_i,
    output cmd_bits_t pulse_o
);

    cmd_bits_t cmd_prev_q;
    cmd_bits_t pulse_q;
    cmd_bits_t pulse_d;

    // Rising-edge detection against the previous cycle's command bits.
    always_comb begin
        pulse_d = cmd_bits_t'(cmd_i & ~cmd_prev_q);
    end

    // History and pulse registers; reset clears history so no pulse follows release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_prev_q <= '0;
            pulse_q    <= '0;
        end else begin
            cmd_prev_q <= cmd_i;
            pulse_q    <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/seeg_axil_regs.sv
// AXI4-Lite slave holding 32 word registers for the SEEG core.
// Ports: AXI4-Lite slave (S_AXI_*), status_i (read at word 1),
//        command pulses (*_p), stim_param0..3 (words 3..6),
//        batch_size (word 19 [15:0]) and loopback (word 20 bit 0).
// AW and W are latched independently; the write commits once both are held
// and BVALID rises on that same edge. Reads return registered data one cycle
// after AR acceptance.
module seeg_axil_regs
    import seeg_regs_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic [31:0]                       status_i,
    output logic                              start_record_p,
    output logic                              stop_record_p,
    output logic                              start_zcheck_p,
    output logic                              start_stim_fin_p,
    output logic                              start_stim_inf_p,
    output logic                              stop_stim_inf_p,
    output logic [31:0]                       stim_param0,
    output logic [31:0]                       stim_param1,
    output logic [31:0]                       stim_param2,
    output logic [31:0]                       stim_param3,
    output logic [15:0]                       batch_size,
    output logic                              loopback
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    logic [DW-1:0] regs_q [NUM_WORDS];
    logic [DW-1:0] regs_d [NUM_WORDS];
    logic          ready_en_q, ready_en_d;
    logic          aw_held_q, aw_held_d;
    logic [4:0]    aw_idx_q, aw_idx_d;
    logic          w_held_q, w_held_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] wstrb_q, wstrb_d;
    logic          bvalid_q, bvalid_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic      aw_fire_s, w_fire_s, ar_fire_s, commit_s;
    logic [4:0] ar_idx_s;
    cmd_bits_t cmd_s, pulse_s;
    logic      unused_s;

    // Ready signals are derived only from registers, so they stay low in reset
    // and rise on the first clock after release via ready_en_q.
    assign S_AXI_AWREADY = ready_en_q & ~aw_held_q & ~bvalid_q;
    assign S_AXI_WREADY  = ready_en_q & ~w_held_q & ~bvalid_q;
    assign S_AXI_ARREADY = ready_en_q & ~rvalid_q;

    assign aw_fire_s = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_fire_s  = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_fire_s = S_AXI_ARVALID & S_AXI_ARREADY;
    assign commit_s  = aw_held_q & w_held_q;
    assign ar_idx_s  = S_AXI_ARADDR[6:2];

    // Write path: latch AW and W separately, commit when both are held.
    always_comb begin
        ready_en_d = 1'b1;
        aw_held_d  = aw_held_q;
        aw_idx_d   = aw_idx_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        regs_d     = regs_q;

        if (commit_s) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            // Word 1 is status; writes to it are dropped.
            if (aw_idx_q != IDX_STATUS) begin
                for (int b = 0; b < SW; b++) begin
                    if (wstrb_q[b]) begin
                        regs_d[aw_idx_q][b*8 +: 8] = wdata_q[b*8 +: 8];
                    end else begin
                        regs_d[aw_idx_q][b*8 +: 8] = regs_q[aw_idx_q][b*8 +: 8];
                    end
                end
            end else begin
                regs_d = regs_q;
            end
        end else begin
            if (aw_fire_s) begin
                aw_held_d = 1'b1;
                aw_idx_d  = S_AXI_AWADDR[6:2];
            end else begin
                aw_held_d = aw_held_q;
            end
            if (w_fire_s) begin
                w_held_d = 1'b1;
                wdata_d  = S_AXI_WDATA;
                wstrb_d  = S_AXI_WSTRB;
            end else begin
                w_held_d = w_held_q;
            end
            if (S_AXI_BREADY) begin
                bvalid_d = 1'b0;
            end else begin
                bvalid_d = bvalid_q;
            end
        end
    end

    // Read path: sample the register array (pre-commit values) or status_i.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (ar_fire_s) begin
            rvalid_d = 1'b1;
            if (ar_idx_s == IDX_STATUS) begin
                rdata_d = status_i;
            end else begin
                rdata_d = regs_q[ar_idx_s];
            end
        end else if (S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
    end

    // Register update for all bus-side state and the word array.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ready_en_q <= 1'b0;
            aw_held_q  <= 1'b0;
            aw_idx_q   <= 5'd0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            ready_en_q <= ready_en_d;
            aw_held_q  <= aw_held_d;
            aw_idx_q   <= aw_idx_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            regs_q     <= regs_d;
        end
    end

    assign cmd_s = cmd_bits_from_word(regs_q[IDX_CMD]);

    seeg_cmd_pulse u_cmd_pulse (
        .clk     (S_AXI_ACLK),
        .rst_n   (S_AXI_ARESETN),
        .cmd_i   (cmd_s),
        .pulse_o (pulse_s)
    );

    assign S_AXI_BRESP      = 2'b00;
    assign S_AXI_BVALID     = bvalid_q;
    assign S_AXI_RRESP      = 2'b00;
    assign S_AXI_RVALID     = rvalid_q;
    assign S_AXI_RDATA      = rdata_q;

    assign start_record_p   = pulse_s.start_record;
    assign stop_record_p    = pulse_s.stop_record;
    assign start_zcheck_p   = pulse_s.start_zcheck;
    assign start_stim_fin_p = pulse_s.start_stim_fin;
    assign start_stim_inf_p = pulse_s.start_stim_inf;
    assign stop_stim_inf_p  = pulse_s.stop_stim_inf;

    assign stim_param0 = regs_q[IDX_STIM0];
    assign stim_param1 = regs_q[IDX_STIM1];
    assign stim_param2 = regs_q[IDX_STIM2];
    assign stim_param3 = regs_q[IDX_STIM3];
    assign batch_size  = regs_q[IDX_BATCH][15:0];
    assign loopback    = regs_q[IDX_LOOPBACK][0];

    // Protection bits and the byte offset carry no meaning for word registers.
    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_seeg_axil_regs.sv
// Self-checking bench for seeg_axil_regs: directed scenarios plus a randomized
// sequence checked against an array model of the 32 words and pulse counts.
module tb_seeg_axil_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  awaddr = 7'd0;
    logic [2:0]  awprot = 3'd0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  wstrb = 4'd0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [6:0]  araddr = 7'd0;
    logic [2:0]  arprot = 3'd0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] status_i = 32'd0;
    logic        p_srec, p_sprec, p_zc, p_sfin, p_sinf, p_spinf;
    logic [31:0] sp0, sp1, sp2, sp3;
    logic [15:0] batch;
    logic        lb;

    int pass_cnt = 0;
    int check_cnt = 0;

    logic [31:0] model [32];
    int exp_pulse [6];
    int act_pulse [6];
    int cmd_pos [6] = '{0, 1, 2, 6, 7, 8};

    always #5 clk = ~clk;

    seeg_axil_regs dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .status_i(status_i),
        .start_record_p(p_srec), .stop_record_p(p_sprec), .start_zcheck_p(p_zc),
        .start_stim_fin_p(p_sfin), .start_stim_inf_p(p_sinf), .stop_stim_inf_p(p_spinf),
        .stim_param0(sp0), .stim_param1(sp1), .stim_param2(sp2), .stim_param3(sp3),
        .batch_size(batch), .loopback(lb)
    );

    // Count every cycle each pulse output is high (sampled mid-cycle).
    always @(negedge clk) begin
        if (p_srec)  act_pulse[0] = act_pulse[0] + 1;
        if (p_sprec) act_pulse[1] = act_pulse[1] + 1;
        if (p_zc)    act_pulse[2] = act_pulse[2] + 1;
        if (p_sfin)  act_pulse[3] = act_pulse[3] + 1;
        if (p_sinf)  act_pulse[4] = act_pulse[4] + 1;
        if (p_spinf) act_pulse[5] = act_pulse[5] + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model of a committed write: byte merge, and one expected pulse per CMD bit 0->1.
    task automatic model_write(input logic [4:0] idx, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] old_v, new_v;
        if (idx != 5'd1) begin
            old_v = model[idx];
            new_v = old_v;
            for (int b = 0; b < 4; b++)
                if (strb[b]) new_v[b*8 +: 8] = data[b*8 +: 8];
            model[idx] = new_v;
            if (idx == 5'd0)
                for (int k = 0; k < 6; k++)
                    if (!old_v[cmd_pos[k]] && new_v[cmd_pos[k]]) exp_pulse[k] = exp_pulse[k] + 1;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        return (idx == 5'd1) ? status_i : model[idx];
    endfunction

    task automatic axi_write(input logic [4:0] idx, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 0, w_done = 0, aw_f, w_f, blocked = 0;
        int cyc = 0, n = 0, held = 0;
        awaddr = {idx, 2'($urandom_range(0, 3))};
        awprot = 3'($urandom_range(0, 7));
        wdata = data;
        wstrb = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            tick();
            if (aw_f) aw_done = 1;
            if (w_f) w_done = 1;
            cyc++;
        end
        awvalid = 1'b0;
        wvalid = 1'b0;
        check_cnt++;
        if (!(aw_done && w_done)) begin
            $display("FAIL wr_accept idx=%0d got aw=%0d w=%0d want both accepted", idx, aw_done, w_done);
            return;
        end else pass_cnt++;
        while (bvalid !== 1'b1 && n < 10) begin tick(); n++; end
        check_cnt++;
        if (n !== 1) $display("FAIL b_latency idx=%0d got %0d cycles want 1", idx, n);
        else pass_cnt++;
        model_write(idx, data, strb);
        for (int i = 0; i < b_dly; i++) begin
            if (bvalid === 1'b1) held++;
            if (awready !== 1'b0 || wready !== 1'b0) blocked = 1;
            tick();
        end
        if (b_dly > 0) begin
            check_cnt++;
            if (held !== b_dly || blocked) $display("FAIL b_hold idx=%0d got held=%0d blocked=%0d want held=%0d blocked=0", idx, held, blocked, b_dly);
            else pass_cnt++;
        end
        bready = 1'b1;
        check_cnt++;
        if (bresp !== 2'b00 || bvalid !== 1'b1) $display("FAIL bresp idx=%0d got resp=%0d valid=%0b want 0 1", idx, bresp, bvalid);
        else pass_cnt++;
        tick();
        bready = 1'b0;
        check_cnt++;
        if (bvalid !== 1'b0) $display("FAIL b_drop idx=%0d got bvalid=%0b want 0", idx, bvalid);
        else pass_cnt++;
    endtask

    task automatic axi_read(input logic [4:0] idx, input int r_dly);
        bit f = 0;
        int n = 0;
        logic [31:0] exp_v;
        araddr = {idx, 2'($urandom_range(0, 3))};
        arprot = 3'($urandom_range(0, 7));
        arvalid = 1'b1;
        while (!f && n < 10) begin
            f = arready;
            exp_v = model_read(idx);
            tick();
            n++;
        end
        arvalid = 1'b0;
        check_cnt++;
        if (!f || rvalid !== 1'b1) begin
            $display("FAIL rd_accept idx=%0d got acc=%0d rvalid=%0b want 1 1", idx, f, rvalid);
            return;
        end else pass_cnt++;
        for (int i = 0; i < r_dly; i++) tick();
        check_cnt++;
        if (rvalid !== 1'b1 || rdata !== exp_v || rresp !== 2'b00)
            $display("FAIL rdata idx=%0d got %h v=%0b resp=%0d want %h 1 0", idx, rdata, rvalid, rresp, exp_v);
        else pass_cnt++;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic check_pulses(input string tag);
        repeat (3) tick();
        for (int k = 0; k < 6; k++) begin
            check_cnt++;
            if (act_pulse[k] !== exp_pulse[k])
                $display("FAIL pulses_%s bit%0d got %0d want %0d", tag, cmd_pos[k], act_pulse[k], exp_pulse[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        check_cnt++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || rdata !== 32'd0 ||
            {p_srec, p_sprec, p_zc, p_sfin, p_sinf, p_spinf} !== 6'b0 || sp0 !== 32'd0 || batch !== 16'd0 || lb !== 1'b0)
            $display("FAIL reset_state got rdy=%b%b%b bv=%b rv=%b rdata=%h", awready, wready, arready, bvalid, rvalid, rdata);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
        check_cnt++;
        if ({awready, wready, arready} !== 3'b111)
            $display("FAIL ready_after_reset got %b%b%b want 111", awready, wready, arready);
        else pass_cnt++;
    endtask

    task automatic test_outputs();
        axi_write(5'd3, 32'h0001_0001, 4'hF, 0, 0, 0);
        axi_write(5'd19, 32'h0000_0A40, 4'hF, 0, 0, 0);
        axi_write(5'd20, 32'h0000_0001, 4'hF, 1, 0, 0);
        check_cnt++;
        if (sp0 !== 32'h0001_0001 || batch !== 16'd2624 || lb !== 1'b1)
            $display("FAIL outputs got sp0=%h batch=%0d lb=%0b want 00010001 2624 1", sp0, batch, lb);
        else pass_cnt++;
    endtask

    task automatic test_cmd_pulse();
        axi_write(5'd0, 32'h4, 4'hF, 0, 0, 0);
        check_cnt++;
        if (p_zc !== 1'b1) $display("FAIL zcheck_rise got %0b want 1", p_zc);
        else pass_cnt++;
        tick();
        check_cnt++;
        if (p_zc !== 1'b0) $display("FAIL zcheck_one_cycle got %0b want 0", p_zc);
        else pass_cnt++;
        axi_write(5'd0, 32'h4, 4'hF, 0, 0, 0);
        axi_write(5'd0, 32'h0, 4'hF, 0, 0, 0);
        axi_write(5'd0, 32'h1C0, 4'hF, 0, 0, 0);
        check_cnt++;
        if ({p_sfin, p_sinf, p_spinf} !== 3'b111) $display("FAIL stim_together got %b want 111", {p_sfin, p_sinf, p_spinf});
        else pass_cnt++;
        axi_write(5'd0, 32'hA5A5_0E38, 4'hF, 0, 2, 0);
        axi_read(5'd0, 0);
        check_pulses("cmd");
    endtask

    task automatic test_w_before_aw();
        axi_write(5'd5, 32'hDEAD_BEEF, 4'hF, 2, 0, 3);
        axi_read(5'd5, 1);
    endtask

    task automatic test_strobe();
        axi_write(5'd4, 32'h0, 4'hF, 0, 0, 0);
        axi_write(5'd4, 32'hFFFF_FFFF, 4'b0010, 0, 0, 0);
        check_cnt++;
        if (sp1 !== 32'h0000_FF00) $display("FAIL strobe got %h want 0000ff00", sp1);
        else pass_cnt++;
        axi_read(5'd4, 0);
    endtask

    task automatic test_status();
        status_i = 32'h1234_5678;
        axi_read(5'd1, 0);
        axi_write(5'd1, 32'h0, 4'hF, 0, 0, 0);
        axi_read(5'd1, 0);
    endtask

    // A read accepted on the commit edge of a write to the same word sees the old value.
    task automatic test_same_cycle_rw();
        logic [31:0] old_v;
        old_v = model[7];
        awaddr = {5'd7, 2'b00};
        wdata = ~old_v;
        wstrb = 4'hF;
        awvalid = 1'b1;
        wvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid = 1'b0;
        araddr = {5'd7, 2'b00};
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check_cnt++;
        if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== old_v)
            $display("FAIL same_cycle_rw got rdata=%h rv=%0b bv=%0b want %h 1 1", rdata, rvalid, bvalid, old_v);
        else pass_cnt++;
        model_write(5'd7, ~old_v, 4'hF);
        bready = 1'b1;
        rready = 1'b1;
        tick();
        bready = 1'b0;
        rready = 1'b0;
        axi_read(5'd7, 0);
    endtask

    task automatic test_random();
        logic [4:0] idx;
        status_i = $urandom;
        for (int it = 0; it < 60; it++) begin
            idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0)
                axi_write(idx, $urandom, 4'($urandom_range(1, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                axi_read(idx, $urandom_range(0, 2));
        end
        check_cnt++;
        if (sp0 !== model[3] || sp1 !== model[4] || sp2 !== model[5] || sp3 !== model[6] ||
            batch !== model[19][15:0] || lb !== model[20][0])
            $display("FAIL rand_outputs got sp0=%h sp3=%h batch=%h lb=%0b want %h %h %h %0b",
                     sp0, sp3, batch, lb, model[3], model[6], model[19][15:0], model[20][0]);
        else pass_cnt++;
        check_pulses("rand");
    endtask

    task automatic test_reset_mid();
        axi_write(5'd0, 32'h0, 4'hF, 0, 0, 0);
        awaddr = {5'd0, 2'b00};
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        rst_n = 1'b0;
        tick();
        check_cnt++;
        if ({awready, wready, arready} !== 3'b000) $display("FAIL ready_in_reset got %b want 000", {awready, wready, arready});
        else pass_cnt++;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        tick();
        // A lone W must not pair with the abandoned AW.
        wdata = 32'h1FF;
        wstrb = 4'hF;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        repeat (2) tick();
        check_cnt++;
        if (bvalid !== 1'b0) $display("FAIL abandoned_aw got bvalid=%0b want 0", bvalid);
        else pass_cnt++;
        axi_read(5'd0, 0);
        axi_read(5'd3, 0);
        axi_read(5'd19, 0);
        check_pulses("reset");
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        for (int k = 0; k < 6; k++) begin exp_pulse[k] = 0; act_pulse[k] = 0; end
        #1;
        test_reset();
        test_outputs();
        test_cmd_pulse();
        test_w_before_aw();
        test_strobe();
        test_status();
        test_same_cycle_rw();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
